// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - stream-fed program loader that holds the CPU in reset until the image checksum verifies
module prog_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         TIMEOUT   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inData,
  input  logic       inValid,
  output logic       inReady,
  input  logic [7:0] cpuAddr,
  output logic [7:0] memAddr,
  output logic [7:0] memData,
  output logic       memWe,
  output logic       cpuRst,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {LEN, DATA, SUM, RUN, ERR} stateT;

  localparam logic [31:0] TimeoutLimit = 32'(TIMEOUT);

  stateT       state;
  logic [8:0]  index;
  logic [8:0]  total;
  logic [7:0]  sum;
  logic [31:0] idle;
  logic [7:0]  wrAddr;
  logic        accept;
  logic        timedOut;
  logic        lastData;

  assign accept   = inValid && inReady;
  assign timedOut = (TimeoutLimit != 32'd0) && (idle + 32'd1 >= TimeoutLimit);
  assign lastData = (index + 9'd1 == total);
  // Once released, the CPU owns the memory address bus.
  assign memAddr  = (state == RUN) ? cpuAddr : wrAddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LEN;
      inReady <= 1'b1;
      memWe   <= 1'b0;
      wrAddr  <= BASE_ADDR;
      memData <= 8'h00;
      cpuRst  <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      index   <= 9'd0;
      total   <= 9'd0;
      sum     <= 8'h00;
      idle    <= 32'd0;
    end else begin
      memWe <= 1'b0;
      case (state)
        LEN: begin
          if (accept) begin
            total <= (inData == 8'h00) ? 9'd256 : {1'b0, inData};
            index <= 9'd0;
            sum   <= 8'h00;
            idle  <= 32'd0;
            state <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            wrAddr  <= BASE_ADDR + index[7:0];
            memData <= inData;
            memWe   <= 1'b1;
            sum     <= sum + inData;
            index   <= index + 9'd1;
            idle    <= 32'd0;
            if (lastData) state <= SUM;
          end else if (timedOut) begin
            state   <= ERR;
            inReady <= 1'b0;
            err     <= 1'b1;
          end else begin
            idle <= idle + 32'd1;
          end
        end
        SUM: begin
          if (accept) begin
            idle    <= 32'd0;
            inReady <= 1'b0;
            if (inData == sum) begin
              state  <= RUN;
              cpuRst <= 1'b0;
              done   <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end else if (timedOut) begin
            state   <= ERR;
            inReady <= 1'b0;
            err     <= 1'b1;
          end else begin
            idle <= idle + 32'd1;
          end
        end
        RUN: ;
        ERR: ;
        default: begin
          state   <= ERR;
          inReady <= 1'b0;
          err     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - table-driven and randomized checks of prog_loader against a stream-level model
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inValid = 1'b0;
  logic [7:0] inData = 8'h00;
  logic [7:0] cpuAddr = 8'h00;

  logic       inReadyA, memWeA, cpuRstA, doneA, errA;
  logic [7:0] memAddrA, memDataA;
  logic       inReadyB, memWeB, cpuRstB, doneB, errB;
  logic [7:0] memAddrB, memDataB;

  always #5 clk = ~clk;

  prog_loader #(.BASE_ADDR(8'h00), .TIMEOUT(4)) dutA (
    .clk(clk), .rst(rst), .inData(inData), .inValid(inValid), .inReady(inReadyA),
    .cpuAddr(cpuAddr), .memAddr(memAddrA), .memData(memDataA), .memWe(memWeA),
    .cpuRst(cpuRstA), .done(doneA), .err(errA)
  );

  prog_loader #(.BASE_ADDR(8'hFE), .TIMEOUT(0)) dutB (
    .clk(clk), .rst(rst), .inData(inData), .inValid(inValid), .inReady(inReadyB),
    .cpuAddr(cpuAddr), .memAddr(memAddrB), .memData(memDataB), .memWe(memWeB),
    .cpuRst(cpuRstB), .done(doneB), .err(errB)
  );

  int          assertions = 0;
  int          failures = 0;
  logic [15:0] wrA[$];
  logic [15:0] wrB[$];
  logic [15:0] expW[$];
  logic [7:0]  stream[$];
  int          gaps[$];

  always @(negedge clk) begin
    if (memWeA) wrA.push_back({memAddrA, memDataA});
    if (memWeB) wrB.push_back({memAddrB, memDataB});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected writes and outcome from the stream and its inter-byte gaps alone.
  task automatic model(input logic [7:0] base, input int tmo, output logic d, output logic e);
    int         n;
    logic [7:0] s8;
    logic [7:0] a;
    expW.delete();
    d  = 1'b0;
    e  = 1'b0;
    s8 = 8'h00;
    n  = (stream[0] == 8'h00) ? 256 : int'(stream[0]);
    for (int k = 1; k < stream.size(); k++) begin
      if (tmo != 0 && gaps[k] >= tmo) begin
        e = 1'b1;
        return;
      end
      if (k <= n) begin
        a = base + 8'(k - 1);
        expW.push_back({a, stream[k]});
        s8 = s8 + stream[k];
      end else begin
        d = (stream[k] == s8);
        e = !d;
        return;
      end
    end
  endtask

  task automatic checkResult(input string tag, input logic [7:0] base, input int tmo,
                             input logic [15:0] got[$], input logic dn, input logic er,
                             input logic rdy, input logic cr);
    logic d, e;
    model(base, tmo, d, e);
    check({tag, " done"}, dn, d);
    check({tag, " err"}, er, e);
    check({tag, " inReady"}, rdy, !(d || e));
    check({tag, " cpuRst"}, cr, !d);
    check({tag, " writes"}, got.size(), expW.size());
    for (int i = 0; i < got.size() && i < expW.size(); i++)
      if (got[i] !== expW[i]) check($sformatf("%s write%0d", tag, i), got[i], expW[i]);
  endtask

  task automatic doReset();
    rst = 1'b1;
    inValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    inValid = 1'b1;
    inData = b;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic runLoad(input bit withReset);
    if (withReset) doReset();
    wrA.delete();
    wrB.delete();
    for (int i = 0; i < stream.size(); i++) begin
      repeat (gaps[i]) @(negedge clk);
      sendByte(stream[i]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    check({tag, " inReadyA"}, inReadyA, 1'b1);
    check({tag, " memWeA"}, memWeA, 1'b0);
    check({tag, " memAddrA"}, memAddrA, 8'h00);
    check({tag, " memAddrB"}, memAddrB, 8'hFE);
    check({tag, " memDataA"}, memDataA, 8'h00);
    check({tag, " cpuRstA"}, cpuRstA, 1'b1);
    check({tag, " doneA"}, doneA, 1'b0);
    check({tag, " errA"}, errA, 1'b0);
    check({tag, " errB"}, errB, 1'b0);
  endtask

  typedef struct {
    int          n;
    logic [63:0] bytes;
    int          gapAt;
    int          gapLen;
    logic        dA, eA, dB, eB;
    int          wA;
  } vecT;

  initial begin
    vecT        vecs[8];
    logic [7:0] s8;
    int         len;

    vecs[0] = '{5, 64'h66_33_22_11_03, -1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 3};
    vecs[1] = '{4, 64'h04_02_01_02,    -1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 2};
    vecs[2] = '{5, 64'h31_CC_BB_AA_03, -1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 3};
    vecs[3] = '{5, 64'h66_33_22_11_03,  2, 3, 1'b1, 1'b0, 1'b1, 1'b0, 3};
    vecs[4] = '{5, 64'h66_33_22_11_03,  2, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[5] = '{5, 64'h66_33_22_11_03,  4, 4, 1'b0, 1'b1, 1'b1, 1'b0, 3};
    vecs[6] = '{5, 64'h66_33_22_11_03,  0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 3};
    vecs[7] = '{5, 64'h66_33_22_11_03,  1, 4, 1'b0, 1'b1, 1'b1, 1'b0, 0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkResetState("reset");

    // Write latency, back-to-back writes and release timing.
    doReset();
    wrA.delete();
    cpuAddr = 8'h3C;
    sendByte(8'h03);
    sendByte(8'h11);
    check("lat we0", memWeA, 1'b1);
    check("lat addr0", memAddrA, 8'h00);
    check("lat data0", memDataA, 8'h11);
    sendByte(8'h22);
    check("b2b we1", memWeA, 1'b1);
    check("b2b addr1", memAddrA, 8'h01);
    sendByte(8'h33);
    check("b2b data2", memDataA, 8'h33);
    sendByte(8'h66);
    check("rel cpuRst", cpuRstA, 1'b0);
    check("rel done", doneA, 1'b1);
    check("rel inReady", inReadyA, 1'b0);
    check("rel we", memWeA, 1'b0);
    check("rel memAddr", memAddrA, 8'h3C);
    cpuAddr = 8'h81;
    #1;
    check("rel track", memAddrA, 8'h81);
    inValid = 1'b1;
    inData = 8'h55;
    repeat (4) @(negedge clk);
    inValid = 1'b0;
    check("run noWrites", wrA.size(), 3);
    check("run done", doneA, 1'b1);

    // Table-driven directed streams.
    foreach (vecs[v]) begin
      stream.delete();
      gaps.delete();
      for (int i = 0; i < vecs[v].n; i++) begin
        stream.push_back(vecs[v].bytes[8*i +: 8]);
        gaps.push_back(i == vecs[v].gapAt ? vecs[v].gapLen : 0);
      end
      runLoad(1'b1);
      check($sformatf("vec%0d doneA", v), doneA, vecs[v].dA);
      check($sformatf("vec%0d errA", v), errA, vecs[v].eA);
      check($sformatf("vec%0d doneB", v), doneB, vecs[v].dB);
      check($sformatf("vec%0d errB", v), errB, vecs[v].eB);
      check($sformatf("vec%0d wrA", v), wrA.size(), vecs[v].wA);
      checkResult($sformatf("vec%0d A", v), 8'h00, 4, wrA, doneA, errA, inReadyA, cpuRstA);
      checkResult($sformatf("vec%0d B", v), 8'hFE, 0, wrB, doneB, errB, inReadyB, cpuRstB);
    end

    // Reset mid-load, then a fresh stream.
    doReset();
    sendByte(8'h03);
    sendByte(8'h5A);
    doReset();
    checkResetState("midrst");
    stream = '{8'h01, 8'h5A, 8'h5A};
    gaps = '{0, 0, 0};
    runLoad(1'b0);
    check("midrst doneA", doneA, 1'b1);
    check("midrst wrA0", wrA.size() > 0 ? wrA[0] : 16'hxxxx, 16'h005A);
    checkResult("midrst A", 8'h00, 4, wrA, doneA, errA, inReadyA, cpuRstA);
    checkResult("midrst B", 8'hFE, 0, wrB, doneB, errB, inReadyB, cpuRstB);

    // L=0 means 256 data bytes.
    stream.delete();
    gaps.delete();
    stream.push_back(8'h00);
    gaps.push_back(0);
    repeat (256) begin
      stream.push_back(8'h01);
      gaps.push_back(0);
    end
    stream.push_back(8'h00);
    gaps.push_back(0);
    runLoad(1'b1);
    check("len0 count", wrA.size(), 256);
    check("len0 done", doneA, 1'b1);
    checkResult("len0 A", 8'h00, 4, wrA, doneA, errA, inReadyA, cpuRstA);
    checkResult("len0 B", 8'hFE, 0, wrB, doneB, errB, inReadyB, cpuRstB);

    // Randomized streams with random stalls.
    for (int it = 0; it < 40; it++) begin
      stream.delete();
      gaps.delete();
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      stream.push_back(8'(len));
      gaps.push_back(int'($urandom_range(0, 3)));
      s8 = 8'h00;
      for (int i = 0; i < (len == 0 ? 256 : len); i++) begin
        stream.push_back(8'($urandom));
        s8 = s8 + stream[stream.size() - 1];
        gaps.push_back(($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : 0);
      end
      if ($urandom_range(0, 3) != 0) stream.push_back(s8);
      else stream.push_back(s8 ^ 8'($urandom_range(1, 255)));
      gaps.push_back(($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : 0);
      cpuAddr = 8'($urandom);
      runLoad(1'b1);
      checkResult($sformatf("rnd%0d A", it), 8'h00, 4, wrA, doneA, errA, inReadyA, cpuRstA);
      checkResult($sformatf("rnd%0d B", it), 8'hFE, 0, wrB, doneB, errB, inReadyB, cpuRstB);
      if (doneB) check($sformatf("rnd%0d muxB", it), memAddrB, cpuAddr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that fills the 8-bit-address memory from a byte stream before the CPU runs, and holds the CPU in reset until the image is written and its checksum verifies. It sits directly upstream of the CPU/Memory pair. While loading, it owns the memory address bus and write port. After a successful load it passes the CPU's address through to memory and releases the CPU's reset.

## Interface
- `BASE_ADDR`, default 8'h00: memory address of the first loaded byte.
- `TIMEOUT`, default 1000: idle-cycle limit between bytes once a load has started. 0 disables the limit.

- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  one clock; reset is synchronous and active-high
- `inData`  in  8  stream byte
- `inValid`  in  1  `inData` valid
- `inReady`  out  1  loader accepts a byte this cycle
- `cpuAddr`  in  8  CPU memory address, forwarded after the load
- `memAddr`  out  8  address to Memory
- `memData`  out  8  write data to Memory
- `memWe`  out  1  memory write strobe, one cycle per byte
- `cpuRst`  out  1  reset to CPU, active-high
- `done`  out  1  load succeeded; sticky until `rst`
- `err`  out  1  checksum or timeout failure; sticky until `rst`

## Operation
- Stream format: length byte L, then data bytes, then checksum byte C.
  - L=0 means 256 data bytes; otherwise L data bytes.
  - C must equal the sum of the data bytes mod 256. L is excluded from the sum.
- A byte is accepted on a rising edge where `inValid` and `inReady` are both 1.
- States:
  - LEN: `inReady`=1. On accept, latch L, clear index and sum, go to DATA.
  - DATA: `inReady`=1. On accept:
    - register the write: `memAddr`=BASE_ADDR+index (8-bit, wraps 8'hFF→8'h00), `memData`=byte;
    - sum += byte (8-bit wrap);
    - index += 1 (9-bit counter);
    - after the final data byte, go to SUM.
  - SUM: `inReady`=1. On accept:
    - if C == sum, go to RUN;
    - otherwise go to ERR.
  - RUN: `inReady`=0, `cpuRst`=0, `done`=1, `memAddr`=`cpuAddr` (combinational mux from the state register), `memWe`=0.
  - ERR: `inReady`=0, `cpuRst`=1, `err`=1, `memWe`=0. Stays here until `rst`.
- Timeout: in DATA or SUM, an idle counter increments on each cycle with no accept and clears on each accept. When it reaches `TIMEOUT`, go to ERR. No timeout applies in LEN.
- In RUN, `inValid` is ignored and no byte is consumed.
- Reset outputs: `inReady`=1, `memWe`=0, `memAddr`=BASE_ADDR, `memData`=0, `cpuRst`=1, `done`=0, `err`=0; state LEN. Index, sum and idle counter clear to 0.
- Reset mid-load: the load is abandoned, bytes already written stay in memory, and the loader waits for a new L.

## Timing
- Write latency: the data byte accepted at edge N appears on `memWe`/`memAddr`/`memData` for the cycle following edge N. The write is registered, with no combinational path from `inData`.
- Back-to-back accepts produce back-to-back single-cycle writes. There is no internal buffering beyond the one write register.
- `memWe` is deasserted on the edge after the last write unless another byte is accepted on that edge.
- Release: the matching C is accepted at edge N. `cpuRst` falls and `done` rises at edge N. `memAddr` follows `cpuAddr` from edge N onward. The CPU's first fetch is at edge N+1.
- Failure: the mismatching C (or the timeout) occurs at edge N. `err` rises at edge N and `inReady` drops at edge N.
- `rst` takes priority over every accept and timeout on the same edge.

## Test plan
- Basic load, BASE_ADDR=0: stream 03,11,22,33,66 → writes 0:11, 1:22, 2:33 in consecutive cycles. `cpuRst` falls on the edge accepting 66, and `memAddr` then tracks `cpuAddr`.
- Bad checksum: stream 02,01,02,04 → both bytes are written, `err`=1, `cpuRst` stays 1, and `inReady`=0 from then on.
- Wrap, BASE_ADDR=8'hFE: stream 03,AA,BB,CC,31 → writes FE:AA, FF:BB, 00:CC, then `done`=1.
- L=0: 256 bytes of 01 followed by C=00 → 256 writes covering all addresses, then `done`=1.
- Stalls and timeout with TIMEOUT=4: drop `inValid` for 3 cycles mid-DATA → the load continues and the idle counter clears on the next accept. Drop `inValid` for 4 cycles → `err`=1.
- Reset mid-load: assert `rst` after 1 of 3 data bytes → all outputs return to reset values. A fresh stream 01,5A,5A then completes with a write at 00:5A and `done`=1.
